// File: rtl/uart_pkg.sv
// Shared types and constants for the UART value formatter.
// ASCII_CRLF_EN appends CR LF after the decimal digits.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV      = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } fmt_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic int unsigned byte_count(input int unsigned num_digits);
`ifdef ASCII_CRLF_EN
    return num_digits + 2;
`else
    return num_digits;
`endif
  endfunction

endpackage

// File: rtl/uart_value_tx_fmt_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per clock, DATA_W steps per
// conversion, done pulses once the BCD result is final and then holds.
module bin2bcd_iter #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BcdW = 4 * NUM_DIGITS;
  localparam int CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

  logic [DATA_W-1:0]      bin_q, bin_d;
  logic [BcdW-1:0]        bcd_q, bcd_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic [BcdW-1:0]        adj;
  logic [BcdW+DATA_W-1:0] shifted;

  // Nibbles of 5 or more are pre-corrected so the shift carries into the next decade.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;
  end

  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start) begin
      bin_d    = value;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d = shifted[BcdW+DATA_W-1:DATA_W];
      bin_d = shifted[DATA_W-1:0];
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == LastStep) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/uart_value_tx_fmt.sv
// Latches a binary value on trig, converts it to fixed-width ASCII decimal and
// streams the bytes to the UART TX. ASCII_CRLF_EN appends CR LF.
module uart_value_tx_fmt
  import uart_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DATA_W-1:0] value,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

  localparam int NumBytes = int'(byte_count(NUM_DIGITS));
  localparam int IdxW     = $clog2(NumBytes + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  fmt_state_e             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   conv_start;
  logic                   conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [7:0]             byte_sel;

  assign conv_start = (state_q == IDLE) && trig;

  bin2bcd_iter #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(conv_start),
    .value(value),
    .done (conv_done),
    .bcd  (bcd)
  );

  // Byte index 0 is the most significant digit.
  always_comb begin
    byte_sel = ASCII_ZERO;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IdxW'(NUM_DIGITS - 1 - d)) begin
        byte_sel = ASCII_ZERO + {4'h0, bcd[4*d +: 4]};
      end
    end
`ifdef ASCII_CRLF_EN
    if (idx_q == IdxW'(NUM_DIGITS)) begin
      byte_sel = ASCII_CR;
    end
    if (idx_q == IdxW'(NUM_DIGITS + 1)) begin
      byte_sel = ASCII_LF;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
